// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the multi-cycle divider.
`timescale 1ns/1ps
package div_pkg;

  localparam logic        RstEnable         = 1'b1;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        Stop              = 1'b1;
  localparam logic        NoStop            = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Magnitude of an operand: two's-complement negate when it is signed and negative.
  function automatic logic [31:0] abs_if_signed(input logic is_signed, input logic [31:0] v);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the partial
// remainder and shift either the restored or the reduced value left.
`timescale 1ns/1ps
module div_step (
  input  logic [64:0] work_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] work_o
);

  logic [32:0] diff;

  // Trial subtraction; diff[32] set means the divisor did not fit this round.
  always_comb begin
    diff = work_i[64:32] - {1'b0, divisor_i};
    if (diff[32]) begin
      work_o = {work_i[63:0], 1'b0};
    end else begin
      work_o = {diff[31:0], work_i[31:0], 1'b1};
    end
  end

endmodule

// File: rtl/div.sv
// Multi-cycle 32-bit DIV/DIVU unit: one quotient bit per cycle, with a
// combinational stall request that holds the pipeline until the result is ready.
`timescale 1ns/1ps
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        dvd_neg_q, dvd_neg_d;
  logic        dvs_neg_q, dvs_neg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [64:0] step_work;
  logic [31:0] final_quo;
  logic [31:0] final_rem;

  div_step u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_work)
  );

  // Sign-correct the last step's magnitudes: quotient negative when signs differ,
  // remainder follows the dividend.
  always_comb begin
    final_quo = step_work[31:0];
    final_rem = step_work[64:33];
    if (dvd_neg_q ^ dvs_neg_q) begin
      final_quo = ~step_work[31:0] + 32'd1;
    end
    if (dvd_neg_q) begin
      final_rem = ~step_work[64:33] + 32'd1;
    end
  end

  // Next-state and next-output logic for the divider FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    result_d  = result_q;
    ready_d   = DivResultNotReady;
    case (state_q)
      DivFree: begin
        result_d = {ZeroWord, ZeroWord};
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = 5'd0;
            work_d    = {ZeroWord, abs_if_signed(signed_div_i, opdata1_i), 1'b0};
            divisor_d = abs_if_signed(signed_div_i, opdata2_i);
            dvd_neg_d = signed_div_i & opdata1_i[31];
            dvs_neg_d = signed_div_i & opdata2_i[31];
          end
        end
      end
      DivByZero: begin
        state_d  = DivEnd;
        result_d = {ZeroWord, ZeroWord};
        ready_d  = DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = {ZeroWord, ZeroWord};
        end else begin
          work_d = step_work;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = DivEnd;
            result_d = {final_rem, final_quo};
            ready_d  = DivResultReady;
          end
        end
      end
      DivEnd: begin
        state_d  = DivFree;
        result_d = {ZeroWord, ZeroWord};
      end
      default: begin
        state_d  = DivFree;
        result_d = {ZeroWord, ZeroWord};
      end
    endcase
  end

  // State and registered outputs; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= DivFree;
      cnt_q     <= 5'd0;
      work_q    <= '0;
      divisor_q <= ZeroWord;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      result_q  <= {ZeroWord, ZeroWord};
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = (start_i == DivStart && state_q != DivEnd) ? Stop : NoStop;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the divider: directed corner cases plus randomized
// divides compared against a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int testsRun;
  int failCount;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference quotient/remainder from ordinary 64-bit integer arithmetic.
  function automatic logic [63:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Run one divide starting at cycle 0. When chained, inputs are driven during
  // the previous DivEnd cycle and cycle 0 is the following one. Returns at the
  // ready cycle with start still high.
  task automatic applyStimulus(input bit chained, input bit scramble,
                               input logic s, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [63:0] exp;
    signed_div = s;
    op1        = a;
    op2        = b;
    start      = 1'b1;
    annul      = 1'b0;
    if (chained) @(negedge clk);
    lat = (b == 32'd0) ? 2 : 33;
    exp = refDiv(s, a, b);
    for (int c = 0; c <= lat; c++) begin
      #1;
      checkOutput("ready", {63'd0, ready}, {63'd0, c == lat});
      checkOutput("stallreq", {63'd0, stallreq}, {63'd0, c < lat});
      if (c == 0) checkOutput("result_idle", result, 64'd0);
      if (c == lat) begin
        checkOutput("result", result, exp);
      end else begin
        if (scramble && c == 5) begin
          op1        = $urandom;
          op2        = $urandom;
          signed_div = ~signed_div;
        end
        @(negedge clk);
      end
    end
  endtask

  // Drop the request after the ready cycle and confirm the outputs clear.
  task automatic idleAfter();
    start = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("ready_after", {63'd0, ready}, 64'd0);
    checkOutput("result_after", result, 64'd0);
    checkOutput("stall_after", {63'd0, stallreq}, 64'd0);
  endtask

  // Start 100/7 and interrupt it in DivOn cycle `when` with annul or reset.
  task automatic abortRun(input bit useReset, input int when);
    signed_div = 1'b0;
    op1        = 32'd100;
    op2        = 32'd7;
    start      = 1'b1;
    annul      = 1'b0;
    for (int c = 0; c <= when; c++) begin
      #1;
      checkOutput("abort_ready", {63'd0, ready}, 64'd0);
      checkOutput("abort_stall", {63'd0, stallreq}, 64'd1);
      if (c == when) begin
        start = 1'b0;
        if (useReset) rst = 1'b1;
        else annul = 1'b1;
      end
      @(negedge clk);
    end
    #1;
    checkOutput(useReset ? "rst_ready" : "annul_ready", {63'd0, ready}, 64'd0);
    checkOutput(useReset ? "rst_result" : "annul_result", result, 64'd0);
    checkOutput(useReset ? "rst_stall" : "annul_stall", {63'd0, stallreq}, 64'd0);
    rst   = 1'b0;
    annul = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput("abort_quiet", {63'd0, ready}, 64'd0);
    end
  endtask

  initial begin
    bit          chain;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    testsRun   = 0;
    failCount  = 0;
    rst        = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    op1        = 32'd0;
    op2        = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_ready", {63'd0, ready}, 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_stall", {63'd0, stallreq}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
    idleAfter();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'd3);
    idleAfter();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    idleAfter();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd1234, 32'd0);
    idleAfter();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd0);
    idleAfter();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    idleAfter();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    idleAfter();

    abortRun(1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
    idleAfter();
    abortRun(1'b1, 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd100, 32'd7);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'd3);
    idleAfter();

    // A start held with annul must not launch anything.
    start = 1'b1;
    annul = 1'b1;
    op1   = 32'd50;
    op2   = 32'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput("annul_block_ready", {63'd0, ready}, 64'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd50, 32'd5);
    idleAfter();

    chain = 1'b0;
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      applyStimulus(chain, 1'b1, s, a, b);
      chain = $urandom_range(0, 1);
      if (!chain) idleAfter();
    end
    if (chain) idleAfter();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit signed/unsigned divider in the EX stage, executing DIV/DIVU. It sits between the EX stage logic and the pipeline controller. While a division is in flight it raises a stall request toward the controller. The controller answers with a stall vector that freezes PC/IF/ID/EX until the result is ready.

## Interface
Parameters: none. Width and state encodings come from the shared defines.

Ports:
- `clk` input 1: single clock. Every state element updates on the rising edge.
- `rst` input 1: synchronous, active-high reset (`RstEnable` = 1'b1).
- `signed_div_i` input 1: 1 selects DIV (signed), 0 selects DIVU.
- `opdata1_i` input 32: dividend.
- `opdata2_i` input 32: divisor.
- `start_i` input 1: request a division. EX holds it high and the operands stable until `ready_o`.
- `annul_i` input 1: abandon the operation in flight (exception/flush).
- `result_o` output 64: {remainder[63:32], quotient[31:0]}. Valid only while `ready_o` = 1.
- `ready_o` output 1: result valid, asserted for exactly one cycle.
- `stallreq_o` output 1: stall request to the pipeline controller, combinational.

## Operation
States (shared defines): DivFree, DivByZero, DivOn, DivEnd.

- **Reset:** state = DivFree, cnt = 0, `result_o` = 0, `ready_o` = 0. Reset wins over all other inputs in every state, including mid-operation.
- **DivFree:**
  - start_i & !annul_i & divisor == 0 → DivByZero.
  - start_i & !annul_i & divisor != 0 → DivOn. Latch operands. If signed_div_i, latch the absolute values (two's-complement negate if bit 31 is set). Set cnt = 0 and the 65-bit working register = {32'b0, |dividend|, 1'b0}.
- **DivByZero:** → DivEnd with result = 64'h0.
- **DivOn:**
  - annul_i → DivFree. No ready, result stays 0.
  - Otherwise perform one restoring step per cycle:
    - Compute diff = work[64:32] − {1'b0, |divisor|}.
    - If diff is negative: work = {work[63:0], 1'b0}.
    - Else: work = {diff[31:0], work[31:0], 1'b1}.
    - cnt increments by 1.
  - On the step where cnt == 31, register the final result and go to DivEnd.
  - Sign correction when signed: quotient is negated if dividend and divisor signs differ; remainder takes the dividend's sign.
- **DivEnd:** `ready_o` = 1, `result_o` = final value. Unconditionally → DivFree next cycle, where `ready_o` = 0 and `result_o` = 0.
- **stallreq_o** = start_i & (state != DivEnd). It is asserted in the same cycle the DIV reaches EX, so the controller freezes EX immediately. It drops in DivEnd, so the EX/MEM register captures the result on that edge.
- All arithmetic is modulo 2^32. Signed 0x80000000 / −1 gives quotient 0x80000000 and remainder 0 (no trap).
- annul_i outside DivOn is ignored, except that it blocks a start in DivFree.

## Timing
- Start sampled on edge E0 (state DivFree). DivOn covers E1..E32, DivEnd at E33 (`ready_o` high during cycle E33..E34), DivFree at E34.
- Normal latency: 33 cycles from the start edge to ready. Divide-by-zero latency: 2 cycles (DivByZero, then DivEnd).
- Back-to-back divides: a new start is sampled in the DivFree cycle after DivEnd. There is no dead cycle beyond DivEnd.
- Operands are sampled only in DivFree. Later changes to operands have no effect.

## Structure
- Shared defines file:
  - Constants: `RstEnable`, `DivFree`/`DivByZero`/`DivOn`/`DivEnd` (2-bit), `DivResultReady`/`DivResultNotReady`, `DivStart`/`DivStop`, `ZeroWord`.
  - The `Stop`/`NoStop` constants used by the stall-request path.
- Single module. Optionally factor the combinational restoring step into sub-module `div_step` (65-bit in, divisor in, 65-bit out).

## Test plan
- **Unsigned 100 / 7:** start at E0 → stallreq_o = 1 E0..E32, ready_o = 1 only at E33, result_o = 64'h00000002_0000000E, then result_o = 0.
- **Signed −8 / 3:** result = {FFFFFFFE, FFFFFFFE}. Signed 7 / −2: result = {00000001, FFFFFFFD}.
- **Divide by zero (either mode):** ready_o at E2, result_o = 64'h0, stallreq_o low from E2.
- **Edge values:**
  - Unsigned FFFFFFFF / 1 → {00000000, FFFFFFFF}.
  - Signed 80000000 / FFFFFFFF → {00000000, 80000000}.
- **Annul:** annul_i pulsed in the 10th DivOn cycle → DivFree next cycle, ready_o never asserts. A fresh 100 / 7 afterwards completes correctly.
- **Reset mid-operation:** rst at DivOn cycle 20 → next cycle all outputs 0 and state DivFree. Back-to-back divides: two starts separated only by DivEnd both return correct results 34 cycles apart.
